dmem_stream_arbiter: RTL and testbench

- Shares one single-ported DMem bank between four stride-access requesters: store port 1, store port 2, load port 1 and load port 2.
- Requesters are indexed 0..3 in that order and are driven by the TPU core load/store command.
- Arbitrates round-robin and latches the winner's base, stride and length.
- Sequences one strided address stream at a time onto the bank, gated by the winner's per-beat valid.
- Reports grant and completion per requester; it is the controller that sits in front of the DMem body.

---
 rtl/dmem_stream_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_stream_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_stream_arbiter.sv
// dmem_stream_arbiter
// Shares one single-ported DMem bank between four strided requesters
// (0 = store 1, 1 = store 2, 2 = load 1, 3 = load 2). In IDLE it picks a
// requester round-robin and latches that requester's base, stride and
// length. In RUN it steps one address stream onto the bank, one beat per
// cycle in which the owner's I_Valid is high.
//
// Ports:
//   clock, reset       rising-edge clock, async active-low reset
//   I_Req[3:0]         level request per requester
//   I_Base/I_Stride    per-requester start address / increment (ADDR_W each)
//   I_Length           per-requester beat count (LEN_W each)
//   I_Valid[3:0]       per-beat enable of the owning requester
//   O_Grant/O_Done     one-hot pulses at stream start / after last beat
//   O_Busy             stream active
//   O_Mem_Req/We/Addr  bank access, write for requesters 0/1
//   O_Mem_Sel          owning requester index, for data muxing
//
// state  | meaning
// IDLE   | no stream active, arbitrating each cycle
// RUN    | stream owned by sel, beat whenever I_Valid[sel] is high

module dmem_stream_arbiter #(
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [3:0]            I_Req,
   input  logic [4*ADDR_W-1:0]   I_Base,
   input  logic [4*ADDR_W-1:0]   I_Stride,
   input  logic [4*LEN_W-1:0]    I_Length,
   input  logic [3:0]            I_Valid,
   output logic [3:0]            O_Grant,
   output logic [3:0]            O_Done,
   output logic                  O_Busy,
   output logic                  O_Mem_Req,
   output logic                  O_Mem_We,
   output logic [ADDR_W-1:0]     O_Mem_Addr,
   output logic [1:0]            O_Mem_Sel
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             state;
   logic [1:0]         rr_ptr;
   logic [1:0]         sel;
   logic [ADDR_W-1:0]  addr;
   logic [ADDR_W-1:0]  stride;
   logic [LEN_W-1:0]   remaining;

   logic               arb_hit;
   logic [1:0]         arb_idx;
   logic [1:0]         cand;
   logic [LEN_W-1:0]   arb_len;
   logic               beat;

   // Scan from the farthest offset down so the nearest set bit after
   // rr_ptr is the one left standing.
   always_comb begin
      arb_hit = 1'b0;
      arb_idx = rr_ptr;
      cand    = rr_ptr;
      for (int k = 3; k >= 0; k--) begin
         cand = rr_ptr + 2'(k);
         if (I_Req[cand]) begin
            arb_hit = 1'b1;
            arb_idx = cand;
         end
      end
   end

   assign arb_len = I_Length[arb_idx*LEN_W +: LEN_W];
   assign beat    = (state == S_RUN) && I_Valid[sel];

   assign O_Mem_Req  = beat;
   assign O_Mem_We   = (state == S_RUN) && !sel[1];
   assign O_Mem_Addr = addr;
   assign O_Mem_Sel  = sel;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         sel       <= '0;
         addr      <= '0;
         stride    <= '0;
         remaining <= '0;
         O_Grant   <= '0;
         O_Done    <= '0;
         O_Busy    <= 1'b0;
      end else begin
         O_Grant <= '0;
         O_Done  <= '0;
         case (state)
            S_IDLE: begin
               if (arb_hit) begin
                  sel       <= arb_idx;
                  addr      <= I_Base[arb_idx*ADDR_W +: ADDR_W];
                  stride    <= I_Stride[arb_idx*ADDR_W +: ADDR_W];
                  remaining <= arb_len;
                  rr_ptr    <= arb_idx + 2'd1;
                  O_Grant   <= 4'b0001 << arb_idx;
                  // Zero-length streams complete on the spot and never touch the bank.
                  if (arb_len == '0) begin
                     O_Done <= 4'b0001 << arb_idx;
                  end else begin
                     state  <= S_RUN;
                     O_Busy <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (beat) begin
                  addr      <= addr + stride;
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) begin
                     state  <= S_IDLE;
                     O_Busy <= 1'b0;
                     O_Done <= 4'b0001 << sel;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_stream_arbiter.sv
// Testbench for dmem_stream_arbiter: table of streams plus hand sequences
// for round-robin, stall, back-to-back zero length and reset abort. A
// negedge monitor pops expected grants and beats from queues filled at
// stimulus time.

module tb_dmem_stream_arbiter;

   localparam int AW = 10;
   localparam int LW = 10;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic [3:0]        I_Req = '0;
   logic [4*AW-1:0]   I_Base = '0;
   logic [4*AW-1:0]   I_Stride = '0;
   logic [4*LW-1:0]   I_Length = '0;
   logic [3:0]        I_Valid = '0;
   logic [3:0]        O_Grant, O_Done;
   logic              O_Busy, O_Mem_Req, O_Mem_We;
   logic [AW-1:0]     O_Mem_Addr;
   logic [1:0]        O_Mem_Sel;

   dmem_stream_arbiter #(.ADDR_W(AW), .LEN_W(LW)) dut (
      .clock(clock), .reset(reset), .I_Req(I_Req), .I_Base(I_Base),
      .I_Stride(I_Stride), .I_Length(I_Length), .I_Valid(I_Valid),
      .O_Grant(O_Grant), .O_Done(O_Done), .O_Busy(O_Busy),
      .O_Mem_Req(O_Mem_Req), .O_Mem_We(O_Mem_We),
      .O_Mem_Addr(O_Mem_Addr), .O_Mem_Sel(O_Mem_Sel)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          idx;
      logic [AW-1:0] base;
      logic [AW-1:0] stride;
      logic [LW-1:0] len;
      logic [3:0]  exp_grant;
      logic        exp_we;
   } vec_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic        we;
      logic [1:0]  sel;
      logic        last;
      logic [3:0]  done_mask;
   } beat_t;

   typedef struct {
      logic [3:0]  mask;
      logic        zero;
   } grant_t;

   beat_t  bq[$];
   grant_t gq[$];
   int     checks = 0;
   int     errors = 0;
   logic   done_pending = 1'b0;
   logic [3:0] done_exp = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Expected model: addresses base + k*stride modulo 2^AW.
   task automatic push_stream(input int idx, input logic [AW-1:0] base,
                              input logic [AW-1:0] stride, input logic [LW-1:0] len);
      grant_t g;
      beat_t  b;
      logic [AW-1:0] a;
      g.mask = 4'b0001 << idx;
      g.zero = (len == 0);
      gq.push_back(g);
      a = base;
      for (int k = 0; k < int'(len); k++) begin
         b.addr = a;
         b.we = (idx < 2);
         b.sel = 2'(idx);
         b.last = (k == int'(len) - 1);
         b.done_mask = 4'b0001 << idx;
         bq.push_back(b);
         a = a + stride;
      end
   endtask

   task automatic set_cfg(input int idx, input logic [AW-1:0] base,
                          input logic [AW-1:0] stride, input logic [LW-1:0] len);
      I_Base[idx*AW +: AW]   = base;
      I_Stride[idx*AW +: AW] = stride;
      I_Length[idx*LW +: LW] = len;
   endtask

   task automatic wait_grant(input int idx, input string name);
      logic got;
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clock); #1;
         if (O_Grant[idx]) begin
            got = 1'b1;
            break;
         end
      end
      chk({name, "_grant_seen"}, 32'(got), 32'd1);
      I_Req[idx] = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      logic ok;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clock); #1;
         if (gq.size() == 0 && bq.size() == 0 && !done_pending && I_Req == 4'b0) begin
            ok = 1'b1;
            break;
         end
      end
      chk({name, "_idle"}, 32'(ok), 32'd1);
   endtask

   always @(negedge clock) begin
      grant_t g;
      beat_t  b;
      logic   dchk;
      dchk = 1'b0;
      if (O_Grant != 4'b0) begin
         if (gq.size() == 0) begin
            checks++; errors++;
            $display("FAIL grant_unexpected actual=%b required=none", O_Grant);
         end else begin
            g = gq.pop_front();
            chk("grant_mask", 32'(O_Grant), 32'(g.mask));
            if (g.zero) begin
               dchk = 1'b1;
               chk("zero_len_done", 32'(O_Done), 32'(g.mask));
               chk("zero_len_busy", 32'(O_Busy), 32'd0);
            end
         end
      end
      if (done_pending) begin
         dchk = 1'b1;
         done_pending = 1'b0;
         chk("done_after_last", 32'(O_Done), 32'(done_exp));
         chk("busy_after_done", 32'(O_Busy), 32'd0);
      end
      if (!dchk && O_Done != 4'b0) begin
         checks++; errors++;
         $display("FAIL done_unexpected actual=%b required=0000", O_Done);
      end
      if (O_Mem_Req) begin
         if (bq.size() == 0) begin
            checks++; errors++;
            $display("FAIL beat_unexpected actual_addr=%0h required=none", O_Mem_Addr);
         end else begin
            b = bq.pop_front();
            chk("beat_addr", 32'(O_Mem_Addr), 32'(b.addr));
            chk("beat_we", 32'(O_Mem_We), 32'(b.we));
            chk("beat_sel", 32'(O_Mem_Sel), 32'(b.sel));
            chk("beat_busy", 32'(O_Busy), 32'd1);
            if (b.last) begin
               done_pending = 1'b1;
               done_exp = b.done_mask;
            end
         end
      end
   end

   task automatic check_all_zero(input string name);
      chk({name, "_grant"}, 32'(O_Grant), 32'd0);
      chk({name, "_done"}, 32'(O_Done), 32'd0);
      chk({name, "_busy"}, 32'(O_Busy), 32'd0);
      chk({name, "_req"}, 32'(O_Mem_Req), 32'd0);
      chk({name, "_we"}, 32'(O_Mem_We), 32'd0);
      chk({name, "_addr"}, 32'(O_Mem_Addr), 32'd0);
      chk({name, "_sel"}, 32'(O_Mem_Sel), 32'd0);
   endtask

   task automatic drain_rr(input string name);
      logic ok;
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clock); #1;
         I_Req = I_Req & ~O_Grant;
         if (I_Req == 4'b0 && gq.size() == 0 && bq.size() == 0 && !done_pending) begin
            ok = 1'b1;
            break;
         end
      end
      chk({name, "_drained"}, 32'(ok), 32'd1);
   endtask

   vec_t vecs[6];
   logic [5:0] pat;

   initial begin
      vecs[0] = '{idx: 2, base: 10'h010, stride: 10'd4,   len: 10'd3, exp_grant: 4'b0100, exp_we: 1'b0};
      vecs[1] = '{idx: 0, base: 10'h3FE, stride: 10'd3,   len: 10'd3, exp_grant: 4'b0001, exp_we: 1'b1};
      vecs[2] = '{idx: 3, base: 10'h050, stride: 10'd1,   len: 10'd0, exp_grant: 4'b1000, exp_we: 1'b0};
      vecs[3] = '{idx: 1, base: 10'h123, stride: 10'h100, len: 10'd5, exp_grant: 4'b0010, exp_we: 1'b1};
      vecs[4] = '{idx: 3, base: 10'h3F0, stride: 10'h3FF, len: 10'd4, exp_grant: 4'b1000, exp_we: 1'b0};
      vecs[5] = '{idx: 0, base: 10'h000, stride: 10'd0,   len: 10'd2, exp_grant: 4'b0001, exp_we: 1'b1};

      // Reset state, with all four requests already held for the RR test.
      #3;
      check_all_zero("reset");
      I_Valid = 4'hF;
      for (int i = 0; i < 4; i++) set_cfg(i, 10'(16'h80 * i), 10'd1, 10'd1);
      for (int i = 0; i < 4; i++) push_stream(i, 10'(16'h80 * i), 10'd1, 10'd1);
      I_Req = 4'hF;
      @(negedge clock); reset = 1'b1;
      drain_rr("rr_first");
      for (int i = 0; i < 4; i++) push_stream(i, 10'(16'h80 * i), 10'd1, 10'd1);
      I_Req = 4'hF;
      drain_rr("rr_second");

      // Table-driven streams.
      for (int v = 0; v < 6; v++) begin
         set_cfg(vecs[v].idx, vecs[v].base, vecs[v].stride, vecs[v].len);
         push_stream(vecs[v].idx, vecs[v].base, vecs[v].stride, vecs[v].len);
         I_Req[vecs[v].idx] = 1'b1;
         wait_grant(vecs[v].idx, "vec");
         chk("vec_grant_value", 32'(O_Grant), 32'(vecs[v].exp_grant));
         chk("vec_busy_at_grant", 32'(O_Busy), 32'(vecs[v].len != 0));
         if (vecs[v].len != 0) chk("vec_we_at_grant", 32'(O_Mem_We), 32'(vecs[v].exp_we));
         // Later config changes must not disturb the active stream.
         set_cfg(vecs[v].idx, 10'h2AA, 10'h155, 10'd7);
         wait_idle("vec");
      end

      // Stall: valid pattern 1,0,0,1,1,1 on requester 1, requester 3 valid toggling.
      I_Valid = 4'b0000;
      set_cfg(1, 10'h200, 10'd5, 10'd4);
      push_stream(1, 10'h200, 10'd5, 10'd4);
      pat = 6'b111001;
      I_Req[1] = 1'b1;
      wait_grant(1, "stall");
      for (int p = 0; p < 6; p++) begin
         I_Valid[1] = pat[p];
         I_Valid[3] = ~I_Valid[3];
         @(negedge clock);
         chk("stall_beat", 32'(O_Mem_Req), 32'(pat[p]));
         @(posedge clock); #1;
      end
      I_Valid = 4'hF;
      wait_idle("stall");

      // Back-to-back zero-length grants on requesters 2 and 3 (rr_ptr is 2 here).
      set_cfg(2, 10'h011, 10'd1, 10'd0);
      set_cfg(3, 10'h022, 10'd1, 10'd0);
      push_stream(2, 10'h011, 10'd1, 10'd0);
      push_stream(3, 10'h022, 10'd1, 10'd0);
      I_Req = 4'b1100;
      @(posedge clock); #1;
      chk("b2b_zero_first", 32'(O_Grant), 32'b0100);
      I_Req = I_Req & ~O_Grant;
      @(posedge clock); #1;
      chk("b2b_zero_second", 32'(O_Grant), 32'b1000);
      I_Req = I_Req & ~O_Grant;
      wait_idle("b2b_zero");

      // Reset mid-stream: three beats then abort, no done.
      set_cfg(0, 10'h100, 10'd1, 10'd8);
      gq.push_back('{mask: 4'b0001, zero: 1'b0});
      for (int k = 0; k < 3; k++)
         bq.push_back('{addr: 10'(10'h100 + k), we: 1'b1, sel: 2'd0, last: 1'b0, done_mask: 4'b0001});
      I_Req[0] = 1'b1;
      wait_grant(0, "rst_mid");
      repeat (3) begin
         @(posedge clock); #1;
      end
      reset = 1'b0;
      #1;
      check_all_zero("rst_mid");
      chk("rst_mid_beats_left", 32'(bq.size()), 32'd0);
      repeat (3) @(posedge clock);
      @(negedge clock); reset = 1'b1;
      set_cfg(0, 10'h100, 10'd1, 10'd2);
      push_stream(0, 10'h100, 10'd1, 10'd2);
      I_Req = 4'b0001;
      wait_grant(0, "rst_fresh");
      wait_idle("rst_fresh");

      chk("final_beat_queue", 32'(bq.size()), 32'd0);
      chk("final_grant_queue", 32'(gq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
